// File: rtl/accum32_pkg.sv
// ---------------------------------------------------------------------------
// accum32_pkg
//   Shared definitions for the operand accumulator slice.
//
//   Contents:
//     ACC_W           - datapath width of the accumulator and operands
//     NUM_OPS_DEFAULT - default burst length for accum32
//     state_t         - accumulator sequencing states (ACCUM, DONE)
//     cnt_width()     - counter width needed to hold 0..num_ops
// ---------------------------------------------------------------------------
package accum32_pkg;

    localparam int ACC_W           = 32;
    localparam int NUM_OPS_DEFAULT = 16;

    // ACCUM : collecting operands, input port open
    // DONE  : burst complete, result presented, input port closed
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // The counter must be able to hold NUM_OPS itself, because the final
    // accept increments it to NUM_OPS before the result is handed off.
    function automatic int cnt_width(input int num_ops);
        return $clog2(num_ops + 1);
    endfunction

endpackage : accum32_pkg

// File: rtl/add32_cs.sv
// ---------------------------------------------------------------------------
// add32_cs
//   Combinational 32-bit adder returning the sum together with unsigned
//   carry-out and two's-complement overflow.
//
//   Ports:
//     a_i [31:0] - first addend (the running accumulator)
//     b_i [31:0] - second addend (the incoming operand)
//     s_o [31:0] - sum modulo 2^32
//     c_o        - unsigned carry-out of bit 31
//     v_o        - signed overflow: both addends share a sign and the sum
//                  has the opposite sign
// ---------------------------------------------------------------------------
module add32_cs
    import accum32_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] s_o,
    output logic             c_o,
    output logic             v_o
);

    logic [ACC_W:0] sum_wide;

    always_comb begin
        sum_wide = {1'b0, a_i} + {1'b0, b_i};
        s_o      = sum_wide[ACC_W-1:0];
        c_o      = sum_wide[ACC_W];
        v_o      = (a_i[ACC_W-1] == b_i[ACC_W-1]) &&
                   (sum_wide[ACC_W-1] != a_i[ACC_W-1]);
    end

endmodule : add32_cs

// File: rtl/accum32.sv
// ---------------------------------------------------------------------------
// accum32
//   Burst accumulator: sums NUM_OPS 32-bit operands taken over a valid/ready
//   input port, tracks sticky carry-out and signed overflow, then presents
//   the result on a valid/ready output port.
//
//   Handshake semantics (both ports): a transfer happens on a rising clk
//   edge where valid and ready are both high. in_rdy and out_vld depend on
//   the state register only, never on in_vld or out_rdy, and out_vld stays
//   high until the transfer, clr or reset.
//
//   Parameters:
//     NUM_OPS - operands per burst, 1..255
//     CNT_W   - counter width, derived from NUM_OPS
//
//   Ports:
//     clk         - clock, rising edge
//     rst_n       - asynchronous active-low reset
//     clr         - synchronous clear of the burst (drops any operand or
//                   result offered in the same cycle into the clear)
//     in_vld      - operand valid
//     in_data     - operand
//     in_rdy      - operand accepted this cycle if in_vld is high
//     out_vld     - burst result valid
//     out_rdy     - downstream takes the result
//     acc         - registered running / final sum
//     cnt         - operands accepted in the current burst
//     cout_sticky - any unsigned carry-out during the burst
//     ovf_sticky  - any signed overflow during the burst
//     dbg_state   - current sequencing state, for debug observation
// ---------------------------------------------------------------------------
module accum32
    import accum32_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEFAULT,
    parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [ACC_W-1:0] in_data,
    output logic             in_rdy,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] cnt,
    output logic             cout_sticky,
    output logic             ovf_sticky,
    output state_t           dbg_state
);

    // Counter value at which the incoming accept is the last of the burst.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             in_accept;
    logic             out_accept;
    logic             last_op;

    logic [ACC_W-1:0] add_s;
    logic             add_c;
    logic             add_v;

    // -----------------------------------------------------------------------
    // Adder core: always adds the operand to the current accumulator; the
    // result is only committed when an operand is actually accepted.
    // -----------------------------------------------------------------------
    add32_cs u_add (
        .a_i (acc_q),
        .b_i (in_data),
        .s_o (add_s),
        .c_o (add_c),
        .v_o (add_v)
    );

    assign in_accept  = in_vld  && in_rdy;
    assign out_accept = out_vld && out_rdy;
    assign last_op    = (cnt_q == LAST_CNT);

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: if (in_accept && last_op) state_d = DONE;
                DONE:  if (out_accept)           state_d = ACCUM;
                default:                         state_d = ACCUM;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs, decoded from the state register alone
    // -----------------------------------------------------------------------
    always_comb begin
        in_rdy    = (state_q == ACCUM);
        out_vld   = (state_q == DONE);
        dbg_state = state_q;
    end

    // -----------------------------------------------------------------------
    // Datapath next-state. clr outranks both handshakes, so an operand
    // offered in the clear cycle is neither summed nor counted.
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (clr || out_accept) begin
            acc_d  = '0;
            cnt_d  = '0;
            cout_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (in_accept) begin
            acc_d  = add_s;
            cnt_d  = cnt_q + CNT_W'(1);
            cout_d = cout_q | add_c;
            ovf_d  = ovf_q  | add_v;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign acc         = acc_q;
    assign cnt         = cnt_q;
    assign cout_sticky = cout_q;
    assign ovf_sticky  = ovf_q;

endmodule : accum32

// File: tb/tb_accum32.sv
module tb_accum32;
  import accum32_pkg::*;

  // -------------------------------------------------------------------------
  // clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // dut4: NUM_OPS=4
  logic        clr4 = 0, in_vld4 = 0, out_rdy4 = 0;
  logic [31:0] in_data4 = '0;
  logic        in_rdy4, out_vld4, cout4, ovf4;
  logic [31:0] acc4;
  logic [2:0]  cnt4;
  state_t      st4;

  // dut2: NUM_OPS=2
  logic        clr2 = 0, in_vld2 = 0, out_rdy2 = 0;
  logic [31:0] in_data2 = '0;
  logic        in_rdy2, out_vld2, cout2, ovf2;
  logic [31:0] acc2;
  logic [1:0]  cnt2;
  state_t      st2;

  // dut1: NUM_OPS=1
  logic        clr1 = 0, in_vld1 = 0, out_rdy1 = 0;
  logic [31:0] in_data1 = '0;
  logic        in_rdy1, out_vld1, cout1, ovf1;
  logic [31:0] acc1;
  logic [0:0]  cnt1;
  state_t      st1;

  accum32 #(.NUM_OPS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .in_vld(in_vld4), .in_data(in_data4),
    .in_rdy(in_rdy4), .out_vld(out_vld4), .out_rdy(out_rdy4), .acc(acc4),
    .cnt(cnt4), .cout_sticky(cout4), .ovf_sticky(ovf4), .dbg_state(st4)
  );

  accum32 #(.NUM_OPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .in_vld(in_vld2), .in_data(in_data2),
    .in_rdy(in_rdy2), .out_vld(out_vld2), .out_rdy(out_rdy2), .acc(acc2),
    .cnt(cnt2), .cout_sticky(cout2), .ovf_sticky(ovf2), .dbg_state(st2)
  );

  accum32 #(.NUM_OPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .in_vld(in_vld1), .in_data(in_data1),
    .in_rdy(in_rdy1), .out_vld(out_vld1), .out_rdy(out_rdy1), .acc(acc1),
    .cnt(cnt1), .cout_sticky(cout1), .ovf_sticky(ovf1), .dbg_state(st1)
  );

  // scoreboard: {cout, ovf, acc} expected per completed burst of dut4
  logic [33:0] exp_q[$];

  // -------------------------------------------------------------------------
  // driver tasks: inputs change 1 time unit after the rising edge, outputs
  // are read at that same point (away from the edge)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed4(input logic [31:0] d);
    in_vld4 = 1'b1; in_data4 = d;
    tick();
    in_vld4 = 1'b0;
  endtask

  task automatic feed2(input logic [31:0] d);
    in_vld2 = 1'b1; in_data2 = d;
    tick();
    in_vld2 = 1'b0;
  endtask

  task automatic take4();
    out_rdy4 = 1'b1;
    tick();
    out_rdy4 = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // tests
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [38:0] obs;
    #1;
    obs = {acc4, cnt4, cout4, ovf4, in_rdy4, out_vld4};
    total++;
    if (obs !== {32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL reset_initial got=%h want=%h", obs, {32'h0, 3'd0, 4'b0010});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    feed4(32'h0000_1000);
    feed4(32'h0000_0200);
    feed4(32'h0000_0034);
    total++;
    if ({acc4, cnt4} !== {32'h0000_1234, 3'd3}) begin
      bad++; $display("FAIL reset_preload acc=%h cnt=%0d want acc=00001234 cnt=3", acc4, cnt4);
    end
    #3 rst_n = 1'b0;
    #1;
    obs = {acc4, cnt4, cout4, ovf4, in_rdy4, out_vld4};
    total++;
    if (obs !== {32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0} || st4 !== ACCUM) begin
      bad++; $display("FAIL reset_async got=%h st=%0d want=%h st=0", obs, st4, {32'h0, 3'd0, 4'b0010});
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_classic();
    feed4(32'h5566_7766);
    total++;
    if (acc4 !== 32'h5566_7766) begin bad++; $display("FAIL classic_op1 acc=%h want=55667766", acc4); end
    feed4(32'hAA99_8899);
    total++;
    if ({acc4, cout4} !== {32'hFFFF_FFFF, 1'b0}) begin
      bad++; $display("FAIL classic_op2 acc=%h cout=%b want acc=ffffffff cout=0", acc4, cout4);
    end
    feed4(32'h0000_0001);
    total++;
    if ({acc4, cout4, ovf4} !== {32'h0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL classic_op3 acc=%h cout=%b ovf=%b want acc=0 cout=1 ovf=0", acc4, cout4, ovf4);
    end
    feed4(32'h0000_0000);
    total++;
    if ({out_vld4, in_rdy4, acc4, cnt4, cout4, ovf4} !== {1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL classic_done vld=%b rdy=%b acc=%h cnt=%0d cout=%b ovf=%b want 1 0 0 4 1 0",
                      out_vld4, in_rdy4, acc4, cnt4, cout4, ovf4);
    end
    take4();
    total++;
    if ({out_vld4, in_rdy4, acc4, cnt4, cout4, ovf4} !== {1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL classic_turnaround vld=%b rdy=%b acc=%h cnt=%0d want vld=0 rdy=1 zeros",
                      out_vld4, in_rdy4, acc4, cnt4);
    end
  endtask

  task automatic test_signed_overflow();
    feed2(32'h7FFF_FFFF);
    feed2(32'h0000_0001);
    total++;
    if ({acc2, ovf2, cout2, out_vld2, cnt2} !== {32'h8000_0000, 1'b1, 1'b0, 1'b1, 2'd2}) begin
      bad++; $display("FAIL signed_ovf acc=%h ovf=%b cout=%b vld=%b cnt=%0d want 80000000 1 0 1 2",
                      acc2, ovf2, cout2, out_vld2, cnt2);
    end
    out_rdy2 = 1'b1; tick(); out_rdy2 = 1'b0;
    total++;
    if ({acc2, ovf2, out_vld2, in_rdy2} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL signed_ovf_clear acc=%h ovf=%b vld=%b rdy=%b", acc2, ovf2, out_vld2, in_rdy2);
    end
  endtask

  task automatic test_backpressure();
    // 0x80000000 + 0x80000000 overflows both ways; then small positives
    feed4(32'h8000_0000);
    feed4(32'h8000_0000);
    feed4(32'h0000_0010);
    feed4(32'h0000_0005);
    for (int i = 0; i < 5; i++) begin
      in_vld4 = 1'b1;
      in_data4 = $urandom;
      out_rdy4 = 1'b0;
      tick();
      total++;
      if ({in_rdy4, out_vld4, acc4, cnt4, cout4, ovf4} !== {1'b0, 1'b1, 32'h0000_0015, 3'd4, 1'b1, 1'b1}) begin
        bad++; $display("FAIL backpressure_hold cyc=%0d rdy=%b vld=%b acc=%h cnt=%0d cout=%b ovf=%b want 0 1 00000015 4 1 1",
                        i, in_rdy4, out_vld4, acc4, cnt4, cout4, ovf4);
      end
    end
    in_vld4 = 1'b0;
    take4();
    total++;
    if ({acc4, cnt4, in_rdy4, out_vld4, cout4, ovf4} !== {32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL backpressure_release acc=%h cnt=%0d rdy=%b vld=%b want 0 0 1 0", acc4, cnt4, in_rdy4, out_vld4);
    end
  endtask

  task automatic test_clr_collision();
    feed4(32'hFFFF_FFFF);
    feed4(32'h0000_0002);
    total++;
    if ({acc4, cnt4, cout4} !== {32'h1, 3'd2, 1'b1}) begin
      bad++; $display("FAIL clr_setup acc=%h cnt=%0d cout=%b want 00000001 2 1", acc4, cnt4, cout4);
    end
    clr4 = 1'b1; in_vld4 = 1'b1; in_data4 = 32'hDEAD_BEEF;
    tick();
    clr4 = 1'b0; in_vld4 = 1'b0;
    total++;
    if ({acc4, cnt4, cout4, ovf4, in_rdy4} !== {32'h0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL clr_collision acc=%h cnt=%0d cout=%b ovf=%b want all zero", acc4, cnt4, cout4, ovf4);
    end
    feed4(32'h0000_0005);
    total++;
    if ({acc4, cnt4} !== {32'h5, 3'd1}) begin
      bad++; $display("FAIL clr_after acc=%h cnt=%0d want 00000005 1", acc4, cnt4);
    end
    // clr while the result waits: result dropped, no retransmission
    feed4(32'h1); feed4(32'h1); feed4(32'h1);
    clr4 = 1'b1; out_rdy4 = 1'b1;
    tick();
    clr4 = 1'b0; out_rdy4 = 1'b0;
    total++;
    if ({out_vld4, in_rdy4, acc4, cnt4} !== {1'b0, 1'b1, 32'h0, 3'd0}) begin
      bad++; $display("FAIL clr_in_done vld=%b rdy=%b acc=%h cnt=%0d want 0 1 0 0", out_vld4, in_rdy4, acc4, cnt4);
    end
  endtask

  task automatic test_num_ops_one();
    in_vld1 = 1'b1; in_data1 = 32'hCAFE_F00D;
    tick();
    in_vld1 = 1'b0;
    total++;
    if ({out_vld1, in_rdy1, acc1, cnt1, cout1, ovf1} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL num_ops_one vld=%b rdy=%b acc=%h cnt=%0d want 1 0 cafef00d 1", out_vld1, in_rdy1, acc1, cnt1);
    end
    out_rdy1 = 1'b1; tick(); out_rdy1 = 1'b0;
    total++;
    if ({out_vld1, in_rdy1, acc1} !== {1'b0, 1'b1, 32'h0}) begin
      bad++; $display("FAIL num_ops_one_take vld=%b rdy=%b acc=%h", out_vld1, in_rdy1, acc1);
    end
  endtask

  task automatic test_random();
    logic [31:0] m_acc = '0;
    logic        m_cout = 1'b0, m_ovf = 1'b0;
    int          m_cnt = 0;
    int          accepted = 0;
    int          bursts_seen = 0;
    int          cycles = 0;
    logic [32:0] sum;
    longint      ssum;
    logic [33:0] exp, obs;
    while ((accepted < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      in_vld4  = (accepted < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      in_data4 = $urandom;
      out_rdy4 = (accepted < 1000) ? ($urandom_range(0, 1) == 1) : 1'b1;
      // decide what the coming edge does, from outputs stable since last edge
      if (out_vld4 && out_rdy4) begin
        obs = {cout4, ovf4, acc4};
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL random_unexpected_result got=%h", obs);
        end else begin
          exp = exp_q.pop_front();
          bursts_seen++;
          if (obs !== exp) begin
            bad++; $display("FAIL random_burst n=%0d got {cout,ovf,acc}=%h want=%h", bursts_seen, obs, exp);
          end
        end
      end
      if (in_vld4 && in_rdy4) begin
        sum  = {1'b0, m_acc} + {1'b0, in_data4};
        ssum = longint'($signed(m_acc)) + longint'($signed(in_data4));
        m_cout = m_cout | sum[32];
        m_ovf  = m_ovf | (ssum > 64'sd2147483647) | (ssum < -64'sd2147483648);
        m_acc  = sum[31:0];
        m_cnt++;
        accepted++;
        if (m_cnt == 4) begin
          exp_q.push_back({m_cout, m_ovf, m_acc});
          m_acc = '0; m_cout = 1'b0; m_ovf = 1'b0; m_cnt = 0;
        end
      end
      tick();
      cycles++;
    end
    in_vld4 = 1'b0; out_rdy4 = 1'b0;
    total++;
    if (cycles >= 20000) begin
      bad++; $display("FAIL random_timeout accepted=%0d pending=%0d", accepted, exp_q.size());
    end
    total++;
    if (bursts_seen !== 250) begin
      bad++; $display("FAIL random_burst_count got=%0d want=250", bursts_seen);
    end
    total++;
    if ({cnt4, in_rdy4, out_vld4} !== {3'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL random_end_state cnt=%0d rdy=%b vld=%b want 0 1 0", cnt4, in_rdy4, out_vld4);
    end
  endtask

  // -------------------------------------------------------------------------
  // sequence + report
  // -------------------------------------------------------------------------
  initial begin
    test_reset();
    test_classic();
    test_signed_overflow();
    test_backpressure();
    test_clr_collision();
    test_num_ops_one();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_accum32
